// File: rtl/ad9122_spi_engine.sv
// 3-wire SPI engine for the AD9122: one write, read or timed delay per handshake.
// Drives SCLK/CS_n/SDIO with direction control and returns read data to the sequencer.
module ad9122_spi_engine #(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 8
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic [1:0]  i_wrrd_mode_sel,
  input  logic [15:0] i_wr_infodata,
  input  logic [7:0]  i_rd_info,
  input  logic [15:0] i_delay_cnt,
  input  logic        datain_valid,
  output logic        datain_ready,
  output logic [7:0]  o_rd_data,
  output logic        o_sclk,
  output logic        o_sda,
  output logic        o_sda_dir,
  input  logic        i_sda,
  output logic        o_cs_n
);

  localparam logic [31:0] HALF_LAST  = 32'(CLK_DIV - 1);
  localparam logic [31:0] GAP_LAST   = 32'(GAP_CYCLES - 1);
  localparam logic [31:0] BIT_CYCLES = 32'(2 * CLK_DIV);

  typedef enum logic [2:0] {GAP, IDLE, LOAD, SHIFT, CS_HOLD, DELAY, DONE} state_t;

  state_t      state, state_d;
  logic [31:0] cnt, cnt_d;
  logic [3:0]  bit_idx, bit_d, nxt_bit;
  logic [15:0] shift_word;
  logic        is_read;
  logic [31:0] delay_last;
  logic [7:0]  rx;
  logic        capture;
  logic        sclk_d, cs_n_d, sda_d, dir_d, ready_d;
  logic [7:0]  rd_data_d;

  // Command capture and read shift register; no reset needed, written before use.
  always_ff @(posedge clk_in) begin
    if (capture) begin
      shift_word <= (i_wrrd_mode_sel == 2'b01) ? {i_rd_info, 8'h00} : i_wr_infodata;
      is_read    <= (i_wrrd_mode_sel == 2'b01);
      // DELAY lasts one cycle less than the full span; DONE supplies the last cycle.
      delay_last <= 32'(i_delay_cnt) * BIT_CYCLES - 32'd2;
    end
    if (state == SHIFT && o_sclk && cnt == 32'd0 && is_read && !bit_idx[3])
      rx <= {rx[6:0], i_sda};
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state        <= GAP;
      cnt          <= '0;
      bit_idx      <= '0;
      o_sclk       <= 1'b0;
      o_cs_n       <= 1'b1;
      o_sda        <= 1'b0;
      o_sda_dir    <= 1'b1;
      datain_ready <= 1'b0;
      o_rd_data    <= 8'h00;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      bit_idx      <= bit_d;
      o_sclk       <= sclk_d;
      o_cs_n       <= cs_n_d;
      o_sda        <= sda_d;
      o_sda_dir    <= dir_d;
      datain_ready <= ready_d;
      o_rd_data    <= rd_data_d;
    end
  end

  // Outputs are computed one cycle ahead so the registered pins line up with the state.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    bit_d     = bit_idx;
    capture   = 1'b0;
    sclk_d    = o_sclk;
    cs_n_d    = o_cs_n;
    sda_d     = o_sda;
    dir_d     = o_sda_dir;
    ready_d   = 1'b0;
    rd_data_d = o_rd_data;
    nxt_bit   = bit_idx - 4'd1;
    case (state)
      GAP: begin
        if (cnt == GAP_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 32'd1;
        end
      end
      IDLE: begin
        if (datain_valid) begin
          capture = 1'b1;
          cnt_d   = '0;
          case (i_wrrd_mode_sel)
            2'b00, 2'b01: begin
              state_d = LOAD;
              cs_n_d  = 1'b0;
              dir_d   = 1'b1;
              sda_d   = i_wrrd_mode_sel[0] ? i_rd_info[7] : i_wr_infodata[15];
            end
            2'b10:   state_d = (i_delay_cnt == 16'd0) ? DONE : DELAY;
            default: state_d = DONE;
          endcase
        end
      end
      LOAD: begin
        state_d = SHIFT;
        bit_d   = 4'd15;
      end
      SHIFT: begin
        if (cnt == HALF_LAST) begin
          cnt_d = '0;
          if (!o_sclk) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (bit_idx == 4'd0) begin
              state_d = CS_HOLD;
            end else begin
              bit_d = nxt_bit;
              // SDIO is handed to the DAC at the start of the data byte of a read.
              if (is_read && !nxt_bit[3]) begin
                sda_d = 1'b0;
                dir_d = 1'b0;
              end else begin
                sda_d = shift_word[nxt_bit];
              end
            end
          end
        end else begin
          cnt_d = cnt + 32'd1;
        end
      end
      CS_HOLD: begin
        if (cnt == HALF_LAST) begin
          state_d = DONE;
          cnt_d   = '0;
          cs_n_d  = 1'b1;
          dir_d   = 1'b1;
          sda_d   = 1'b0;
        end else begin
          cnt_d = cnt + 32'd1;
        end
      end
      DELAY: begin
        if (cnt == delay_last) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 32'd1;
        end
      end
      DONE: begin
        ready_d = 1'b1;
        if (is_read) rd_data_d = rx;
        state_d = GAP;
        cnt_d   = '0;
      end
      default: state_d = GAP;
    endcase
  end

endmodule

// File: tb/tb_ad9122_spi_engine.sv
// Directed bench for ad9122_spi_engine: write, read, delay, no-op, back-to-back
// sequencing and mid-command reset, with a falling-edge SDIO slave for reads.
module tb_ad9122_spi_engine;

  localparam int CLK_DIV    = 4;
  localparam int GAP_CYCLES = 8;

  logic        clk_in = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  i_wrrd_mode_sel = 2'b00;
  logic [15:0] i_wr_infodata = 16'h0000;
  logic [7:0]  i_rd_info = 8'h00;
  logic [15:0] i_delay_cnt = 16'h0000;
  logic        datain_valid = 1'b0;
  logic        datain_ready;
  logic [7:0]  o_rd_data;
  logic        o_sclk, o_sda, o_sda_dir, o_cs_n;
  logic        i_sda = 1'b0;

  int tests = 0;
  int fails = 0;

  logic [15:0] sda_bits, dir_bits;
  int          cs_low, rises, rdy_cnt, rdy_at;
  logic [7:0]  rd_at_rdy;

  logic [7:0]  slave_byte = 8'h07;
  int          fall_cnt = 0;

  ad9122_spi_engine #(.CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP_CYCLES)) dut (
    .clk_in(clk_in), .rst(rst), .i_wrrd_mode_sel(i_wrrd_mode_sel),
    .i_wr_infodata(i_wr_infodata), .i_rd_info(i_rd_info), .i_delay_cnt(i_delay_cnt),
    .datain_valid(datain_valid), .datain_ready(datain_ready), .o_rd_data(o_rd_data),
    .o_sclk(o_sclk), .o_sda(o_sda), .o_sda_dir(o_sda_dir), .i_sda(i_sda), .o_cs_n(o_cs_n)
  );

  always #5 clk_in = ~clk_in;

  // DAC model: presents read data bits 7..0 on the falling SCLK edges ending bits 8..1.
  always @(negedge o_sclk or posedge o_cs_n) begin
    if (o_cs_n) fall_cnt = 0;
    else begin
      fall_cnt = fall_cnt + 1;
      if (fall_cnt >= 8 && fall_cnt <= 15) i_sda = slave_byte[15 - fall_cnt];
    end
  end

  // Issues one command from an idle engine and records bus activity until ready.
  // Cycle 1 is the cycle after the IDLE sample; inputs are scrambled right after it.
  task automatic run_cmd(input logic [1:0] mode, input logic [15:0] wr,
                         input logic [7:0] rd, input logic [15:0] dly);
    logic prev_sclk;
    sda_bits = '0; dir_bits = '0; cs_low = 0; rises = 0; rdy_cnt = 0; rdy_at = -1;
    rd_at_rdy = 8'hxx;
    prev_sclk = o_sclk;
    i_wrrd_mode_sel = mode; i_wr_infodata = wr; i_rd_info = rd; i_delay_cnt = dly;
    datain_valid = 1'b1;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk_in);
      if (k == 1) begin
        i_wrrd_mode_sel = ~mode; i_wr_infodata = ~wr; i_rd_info = ~rd; i_delay_cnt = 16'hFFFF;
      end
      if (o_sclk && !prev_sclk) begin
        rises++;
        sda_bits = {sda_bits[14:0], o_sda};
        dir_bits = {dir_bits[14:0], o_sda_dir};
      end
      if (!o_cs_n) cs_low++;
      if (datain_ready) begin
        rdy_cnt++;
        if (rdy_at < 0) begin
          rdy_at = k;
          rd_at_rdy = o_rd_data;
        end
        datain_valid = 1'b0;
      end
      prev_sclk = o_sclk;
      if (rdy_at >= 0 && k >= rdy_at + 3) break;
    end
    datain_valid = 1'b0;
    repeat (GAP_CYCLES + 2) @(negedge clk_in);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk_in);
    tests++; if (o_sclk !== 1'b0) begin fails++; $display("FAIL reset_sclk got %b want 0", o_sclk); end
    tests++; if (o_cs_n !== 1'b1) begin fails++; $display("FAIL reset_cs_n got %b want 1", o_cs_n); end
    tests++; if (o_sda !== 1'b0) begin fails++; $display("FAIL reset_sda got %b want 0", o_sda); end
    tests++; if (o_sda_dir !== 1'b1) begin fails++; $display("FAIL reset_dir got %b want 1", o_sda_dir); end
    tests++; if (datain_ready !== 1'b0) begin fails++; $display("FAIL reset_ready got %b want 0", datain_ready); end
    tests++; if (o_rd_data !== 8'h00) begin fails++; $display("FAIL reset_rd_data got %h want 00", o_rd_data); end
    rst = 1'b0;
    repeat (GAP_CYCLES + 2) @(negedge clk_in);
  endtask

  task automatic test_write;
    run_cmd(2'b00, 16'h0020, 8'h00, 16'h0000);
    tests++; if (sda_bits !== 16'h0020) begin fails++; $display("FAIL write_bits got %h want 0020", sda_bits); end
    tests++; if (rises !== 16) begin fails++; $display("FAIL write_rises got %0d want 16", rises); end
    tests++; if (cs_low !== 133) begin fails++; $display("FAIL write_cs_low got %0d want 133", cs_low); end
    tests++; if (rdy_cnt !== 1) begin fails++; $display("FAIL write_ready_count got %0d want 1", rdy_cnt); end
    tests++; if (rdy_at !== 135) begin fails++; $display("FAIL write_ready_at got %0d want 135", rdy_at); end
    tests++; if (dir_bits !== 16'hFFFF) begin fails++; $display("FAIL write_dir got %h want ffff", dir_bits); end
  endtask

  task automatic test_read;
    slave_byte = 8'h07;
    run_cmd(2'b01, 16'h0000, 8'h98, 16'h0000);
    tests++; if (sda_bits[15:8] !== 8'h98) begin fails++; $display("FAIL read_instr got %h want 98", sda_bits[15:8]); end
    tests++; if (sda_bits[7:0] !== 8'h00) begin fails++; $display("FAIL read_sda_low got %h want 00", sda_bits[7:0]); end
    tests++; if (dir_bits !== 16'hFF00) begin fails++; $display("FAIL read_dir got %h want ff00", dir_bits); end
    tests++; if (cs_low !== 133) begin fails++; $display("FAIL read_cs_low got %0d want 133", cs_low); end
    tests++; if (rdy_at !== 135) begin fails++; $display("FAIL read_ready_at got %0d want 135", rdy_at); end
    tests++; if (rd_at_rdy !== 8'h07) begin fails++; $display("FAIL read_data got %h want 07", rd_at_rdy); end
    run_cmd(2'b00, 16'h1255, 8'h00, 16'h0000);
    tests++; if (o_rd_data !== 8'h07) begin fails++; $display("FAIL read_hold got %h want 07", o_rd_data); end
    tests++; if (sda_bits !== 16'h1255) begin fails++; $display("FAIL read_follow_write got %h want 1255", sda_bits); end
  endtask

  task automatic test_noop;
    run_cmd(2'b11, 16'hFFFF, 8'hFF, 16'h0003);
    tests++; if (rises !== 0) begin fails++; $display("FAIL noop_sclk got %0d want 0", rises); end
    tests++; if (cs_low !== 0) begin fails++; $display("FAIL noop_cs got %0d want 0", cs_low); end
    tests++; if (rdy_at !== 2) begin fails++; $display("FAIL noop_ready_at got %0d want 2", rdy_at); end
    tests++; if (o_rd_data !== 8'h07) begin fails++; $display("FAIL noop_rd_data got %h want 07", o_rd_data); end
  endtask

  task automatic test_delay;
    run_cmd(2'b10, 16'hFFFF, 8'hFF, 16'd4);
    tests++; if (rises !== 0) begin fails++; $display("FAIL delay_sclk got %0d want 0", rises); end
    tests++; if (cs_low !== 0) begin fails++; $display("FAIL delay_cs got %0d want 0", cs_low); end
    tests++; if (rdy_at !== 33) begin fails++; $display("FAIL delay_ready_at got %0d want 33", rdy_at); end
    tests++; if (rdy_cnt !== 1) begin fails++; $display("FAIL delay_ready_count got %0d want 1", rdy_cnt); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] words [5];
    logic [15:0] cur;
    logic prev_sclk, prev_cs;
    int idx, xfer, gap;
    words = '{16'h0123, 16'h4567, 16'h09AB, 16'h4DEF, 16'h5A5A};
    idx = 0; xfer = 0; gap = 0; cur = '0;
    prev_sclk = o_sclk; prev_cs = o_cs_n;
    i_wrrd_mode_sel = 2'b00; i_wr_infodata = words[0]; datain_valid = 1'b1;
    for (int k = 0; k < 3000 && idx < 5; k++) begin
      @(negedge clk_in);
      if (o_sclk && !prev_sclk && !o_cs_n) cur = {cur[14:0], o_sda};
      if (!o_cs_n && prev_cs && xfer > 0) begin
        tests++;
        if (gap < GAP_CYCLES + 1) begin fails++; $display("FAIL b2b_gap%0d got %0d want >=%0d", xfer, gap, GAP_CYCLES + 1); end
      end
      if (o_cs_n && !prev_cs) begin
        tests++;
        if (xfer < 5 && cur !== words[xfer]) begin fails++; $display("FAIL b2b_word%0d got %h want %h", xfer, cur, words[xfer]); end
        xfer++;
        gap = 0;
      end
      if (o_cs_n) gap++;
      if (datain_ready) begin
        idx++;
        if (idx < 5) i_wr_infodata = words[idx];
        else datain_valid = 1'b0;
      end
      prev_sclk = o_sclk; prev_cs = o_cs_n;
    end
    datain_valid = 1'b0;
    tests++; if (idx !== 5) begin fails++; $display("FAIL b2b_ready_count got %0d want 5", idx); end
    tests++; if (xfer !== 5) begin fails++; $display("FAIL b2b_xfers got %0d want 5", xfer); end
    repeat (GAP_CYCLES + 2) @(negedge clk_in);
  endtask

  task automatic test_reset_midcmd;
    logic prev_sclk;
    int r, stray, cs_act;
    r = 0; stray = 0; cs_act = 0;
    prev_sclk = o_sclk;
    i_wrrd_mode_sel = 2'b00; i_wr_infodata = 16'hA5C3; datain_valid = 1'b1;
    for (int k = 0; k < 400 && r < 10; k++) begin
      @(negedge clk_in);
      if (o_sclk && !prev_sclk) r++;
      prev_sclk = o_sclk;
    end
    tests++; if (r !== 10) begin fails++; $display("FAIL midrst_reach_bit6 got %0d want 10", r); end
    rst = 1'b1;
    datain_valid = 1'b0;
    #1;
    tests++; if (o_cs_n !== 1'b1) begin fails++; $display("FAIL midrst_cs_n got %b want 1", o_cs_n); end
    tests++; if (o_sclk !== 1'b0) begin fails++; $display("FAIL midrst_sclk got %b want 0", o_sclk); end
    @(negedge clk_in);
    rst = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk_in);
      if (datain_ready) stray++;
      if (!o_cs_n) cs_act++;
    end
    tests++; if (stray !== 0) begin fails++; $display("FAIL midrst_no_ready got %0d want 0", stray); end
    tests++; if (cs_act !== 0) begin fails++; $display("FAIL midrst_cs_idle got %0d want 0", cs_act); end
    tests++; if (o_rd_data !== 8'h00) begin fails++; $display("FAIL midrst_rd_data got %h want 00", o_rd_data); end
    run_cmd(2'b00, 16'h1234, 8'h00, 16'h0000);
    tests++; if (sda_bits !== 16'h1234) begin fails++; $display("FAIL midrst_next_bits got %h want 1234", sda_bits); end
    tests++; if (rdy_at !== 135) begin fails++; $display("FAIL midrst_next_ready got %0d want 135", rdy_at); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_noop();
    test_delay();
    test_back_to_back();
    test_reset_midcmd();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ad9122_spi_engine.md
# ad9122_spi_engine

Bit-level 3-wire SPI engine for the AD9122 DAC, sitting directly downstream of the DAC configuration sequencer. It accepts one command per valid/ready handshake: a 16-bit register write, an 8-bit instruction plus 8-bit register read, or a timed delay. It drives SCLK, CS_n and a bidirectional SDIO (output value plus direction) and returns read data to the sequencer.

## Interface
- CLK_DIV, 4: clk_in cycles per SCLK half-period (≥1); one bit takes 2·CLK_DIV cycles.
- GAP_CYCLES, 8: minimum clk_in cycles with CS_n high between commands (≥3).
- clk_in  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_wrrd_mode_sel  in  2  2'b00 write, 2'b01 read, 2'b10 delay, 2'b11 no-op.
- i_wr_infodata  in  16  write word: {R/W=0, addr[6:0], data[7:0]}; MSB is sent first.
- i_rd_info  in  8  read instruction: {R/W=1, addr[6:0]}.
- i_delay_cnt  in  16  delay length in SCLK periods.
- datain_valid  in  1  command request, held high by the sequencer.
- datain_ready  out  1  one-cycle pulse when the current command completes.
- o_rd_data  out  8  last read result; holds until the next read completes.
- o_sclk  out  1  SPI clock; idles low.
- o_sda  out  1  SDIO output value.
- o_sda_dir  out  1  1 = FPGA drives SDIO, 0 = DAC drives SDIO.
- i_sda  in  1  SDIO input value.
- o_cs_n  out  1  chip select, active low.

## Operation
- States: GAP, IDLE, LOAD, SHIFT, CS_HOLD, DELAY, DONE.
- Reset: enter GAP with the counter cleared. Outputs reset to o_sclk=0, o_cs_n=1, o_sda=0, o_sda_dir=1, datain_ready=0, o_rd_data=0.
- GAP: count GAP_CYCLES, then go to IDLE.
- IDLE: when datain_valid=1, sample the mode and all command inputs into internal registers; go to LOAD (write/read), DELAY (delay) or DONE (no-op). With datain_valid=0, stay in IDLE.
- Inputs are sampled only in IDLE. Later input changes do not affect a command in flight.
- LOAD (1 cycle): o_cs_n=0, o_sda = bit 15 of the 16-bit shift word, o_sda_dir=1. The shift word is {i_wr_infodata} for a write and {i_rd_info, 8'h00} for a read.
- SHIFT, 16 bits, MSB first. Each bit is CLK_DIV cycles with SCLK low, then CLK_DIV cycles with SCLK high.
- o_sda changes only at the start of a low phase, so data is stable around each rising edge.
- Read, bits 7..0: o_sda_dir=0 from the start of bit 7's low phase until the end of CS_HOLD; o_sda=0 meanwhile.
- Read sampling: i_sda is shifted in MSB-first on the clk_in cycle in which SCLK goes high, for bits 7..0.
- CS_HOLD: SCLK low for CLK_DIV cycles; then o_cs_n=1 and o_sda_dir=1; go to DONE.
- DELAY: CS_n stays high and SCLK stays low for i_delay_cnt·2·CLK_DIV cycles. i_delay_cnt=0 goes straight to DONE.
- DONE (1 cycle): datain_ready=1. For a read, o_rd_data is updated in the same cycle. Then go to GAP.
- If datain_valid drops mid-command, the command still completes and datain_ready still pulses.

## Timing
- CS_n low span, read or write: 1 + 32·CLK_DIV + CLK_DIV cycles (133 at CLK_DIV=4).
- datain_ready pulses the cycle after CS_n rises.
- Back-to-back commands:
  - CS_n high for at least GAP_CYCLES+1 cycles between transfers.
  - The sequencer's next command must be stable within 2 cycles after the ready pulse; GAP_CYCLES≥3 guarantees this.
- No-op: datain_ready pulses 2 cycles after IDLE samples the command (IDLE→DONE), with no bus activity.
- Delay: ready pulses i_delay_cnt·2·CLK_DIV + 1 cycles after the IDLE sample.
- rst asserted mid-command: outputs take their reset values asynchronously (CS_n high immediately), no ready pulse, restart from GAP.

## Test plan
- Write 0x0020 (CLK_DIV=4): SDIO bits sampled at the 16 SCLK rises = 0000_0000_0010_0000. CS_n low for 133 cycles. One ready pulse. o_sda_dir stays 1.
- Read instruction 0x98 with a slave model returning 0x07 on falling edges:
  - first 8 bits = 1001_1000; o_sda_dir=0 for the last 8 bits;
  - o_rd_data=0x07 at ready, held through a following write.
- Delay i_delay_cnt=4: no SCLK toggles, CS_n high throughout, ready exactly 33 cycles after the IDLE sample.
- Sequencer model advancing on ready across 5 writes:
  - each transfer uses the newly registered word (no stale data);
  - CS_n gaps ≥ GAP_CYCLES+1.
- rst pulsed at bit 6 of a write: o_cs_n=1, o_sclk=0 within the same cycle, no ready; the next command runs normally.
- Mode 2'b11: no SCLK/CS_n activity, ready 2 cycles after the sample; o_rd_data unchanged.
